// File: rtl/ptw_mem_arbiter_if.sv
// Bundle of the two TLB walk ports and the single AXI-master read channel
// shared by the page-table-walk memory arbiter.
interface ptw_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  REQ0_VALID;
    logic [ADDR_WIDTH-1:0] REQ0_ADDR;
    logic                  RESP0_VALID;
    logic [DATA_WIDTH-1:0] RESP0_DATA;
    logic                  RESP0_ERR;
    logic                  REQ1_VALID;
    logic [ADDR_WIDTH-1:0] REQ1_ADDR;
    logic                  RESP1_VALID;
    logic [DATA_WIDTH-1:0] RESP1_DATA;
    logic                  RESP1_ERR;
    logic                  MEM_ADDR_VALID;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic                  MEM_READY;
    logic                  MEM_DATA_VALID;
    logic [DATA_WIDTH-1:0] MEM_DATA;
    logic                  BUSY;
    logic                  OWNER;

    modport slave (
        input  REQ0_VALID, REQ0_ADDR, REQ1_VALID, REQ1_ADDR,
        input  MEM_READY, MEM_DATA_VALID, MEM_DATA,
        output RESP0_VALID, RESP0_DATA, RESP0_ERR,
        output RESP1_VALID, RESP1_DATA, RESP1_ERR,
        output MEM_ADDR_VALID, MEM_ADDR, BUSY, OWNER
    );

    modport master (
        output REQ0_VALID, REQ0_ADDR, REQ1_VALID, REQ1_ADDR,
        output MEM_READY, MEM_DATA_VALID, MEM_DATA,
        input  RESP0_VALID, RESP0_DATA, RESP0_ERR,
        input  RESP1_VALID, RESP1_DATA, RESP1_ERR,
        input  MEM_ADDR_VALID, MEM_ADDR, BUSY, OWNER
    );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter giving the ITLB (port 0) and DTLB (port 1) walkers
// one-at-a-time access to a single memory read channel, with a WAIT watchdog.
module ptw_mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic               CLK,
    input  logic               RST,
    ptw_mem_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            state_r;
    logic                  pend0_r;
    logic                  pend1_r;
    logic [ADDR_WIDTH-1:0] addr0_r;
    logic [ADDR_WIDTH-1:0] addr1_r;
    logic                  last_grant_r;
    logic                  owner_r;
    logic [7:0]            cnt_r;
    logic                  mem_addr_valid_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  resp0_valid_r;
    logic [DATA_WIDTH-1:0] resp0_data_r;
    logic                  resp0_err_r;
    logic                  resp1_valid_r;
    logic [DATA_WIDTH-1:0] resp1_data_r;
    logic                  resp1_err_r;
    logic                  grant_s;
    logic                  win_s;

    // Grant decision from the registered pending flags (round-robin on conflict)
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if ((state_r == IDLE) && (pend0_r || pend1_r)) begin
            grant_s = 1'b1;
            if (pend0_r && pend1_r) begin
                win_s = ~last_grant_r;
            end else begin
                win_s = pend1_r;
            end
        end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
        end
    end

    // Per-port pending flag and address; a new request beats a same-cycle grant clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend0_r <= 1'b0;
            pend1_r <= 1'b0;
            addr0_r <= '0;
            addr1_r <= '0;
        end else begin
            if (bus.REQ0_VALID) begin
                pend0_r <= 1'b1;
                addr0_r <= bus.REQ0_ADDR;
            end else if (grant_s && !win_s) begin
                pend0_r <= 1'b0;
            end
            if (bus.REQ1_VALID) begin
                pend1_r <= 1'b1;
                addr1_r <= bus.REQ1_ADDR;
            end else if (grant_s && win_s) begin
                pend1_r <= 1'b0;
            end
        end
    end

    // Transaction sequencer, watchdog and registered response outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r          <= IDLE;
            last_grant_r     <= 1'b1;
            owner_r          <= 1'b0;
            cnt_r            <= 8'd0;
            mem_addr_valid_r <= 1'b0;
            mem_addr_r       <= '0;
            resp0_valid_r    <= 1'b0;
            resp0_data_r     <= '0;
            resp0_err_r      <= 1'b0;
            resp1_valid_r    <= 1'b0;
            resp1_data_r     <= '0;
            resp1_err_r      <= 1'b0;
        end else begin
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        mem_addr_r       <= win_s ? addr1_r : addr0_r;
                        owner_r          <= win_s;
                        last_grant_r     <= win_s;
                        mem_addr_valid_r <= 1'b1;
                        state_r          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.MEM_READY) begin
                        mem_addr_valid_r <= 1'b0;
                        cnt_r            <= 8'd0;
                        state_r          <= WAIT;
                    end
                end
                WAIT: begin
                    // Data wins over a watchdog expiry landing in the same cycle
                    if (bus.MEM_DATA_VALID || (cnt_r == CNT_LAST)) begin
                        if (owner_r) begin
                            resp1_valid_r <= 1'b1;
                            resp1_data_r  <= bus.MEM_DATA_VALID ? bus.MEM_DATA : '0;
                            resp1_err_r   <= ~bus.MEM_DATA_VALID;
                        end else begin
                            resp0_valid_r <= 1'b1;
                            resp0_data_r  <= bus.MEM_DATA_VALID ? bus.MEM_DATA : '0;
                            resp0_err_r   <= ~bus.MEM_DATA_VALID;
                        end
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    mem_addr_valid_r <= 1'b0;
                    state_r          <= IDLE;
                end
            endcase
        end
    end

    assign bus.MEM_ADDR_VALID = mem_addr_valid_r;
    assign bus.MEM_ADDR       = mem_addr_r;
    assign bus.BUSY           = (state_r != IDLE);
    assign bus.OWNER          = owner_r;
    assign bus.RESP0_VALID    = resp0_valid_r;
    assign bus.RESP0_DATA     = resp0_data_r;
    assign bus.RESP0_ERR      = resp0_err_r;
    assign bus.RESP1_VALID    = resp1_valid_r;
    assign bus.RESP1_DATA     = resp1_data_r;
    assign bus.RESP1_ERR      = resp1_err_r;
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level reference model of the arbiter.
module tb_ptw_mem_arbiter;
    localparam int TMO = 8;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_err;

    ptw_mem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    ptw_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference model: pending requests, the in-flight transaction and last responses
    bit          m_pend [2];
    logic [63:0] m_paddr[2];
    bit          m_last;
    bit          m_busy;
    bit          m_addr_phase;
    int          m_wcnt;
    bit          m_owner;
    logic [63:0] m_mem_addr;
    bit          m_rv [2];
    logic [63:0] m_rd [2];
    bit          m_re [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0; m_paddr[p] = 64'd0;
            m_rv[p] = 1'b0; m_rd[p] = 64'd0; m_re[p] = 1'b0;
        end
        m_last = 1'b1; m_busy = 1'b0; m_addr_phase = 1'b0;
        m_wcnt = 0; m_owner = 1'b0; m_mem_addr = 64'd0;
    endtask

    task automatic finish_txn(input logic [63:0] d, input bit err);
        m_rv[m_owner] = 1'b1;
        m_rd[m_owner] = d;
        m_re[m_owner] = err;
        m_busy = 1'b0;
    endtask

    // one clock: drive inputs, advance the model by the rules, then compare everything
    task automatic step(input bit r0, input logic [63:0] a0, input bit r1, input logic [63:0] a1,
                        input bit rdy, input bit dv, input logic [63:0] d, input bit rst);
        bit win;
        bit granted;
        RST = rst;
        bus.REQ0_VALID = r0; bus.REQ0_ADDR = a0;
        bus.REQ1_VALID = r1; bus.REQ1_ADDR = a1;
        bus.MEM_READY = rdy; bus.MEM_DATA_VALID = dv; bus.MEM_DATA = d;
        if (rst) begin
            model_reset();
        end else begin
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            granted = 1'b0; win = 1'b0;
            if (!m_busy) begin
                if (m_pend[0] || m_pend[1]) begin
                    if (m_pend[0] && m_pend[1]) win = !m_last;
                    else win = m_pend[1];
                    granted = 1'b1;
                end
            end else if (m_addr_phase) begin
                if (rdy) begin m_addr_phase = 1'b0; m_wcnt = 0; end
            end else if (dv) begin
                finish_txn(d, 1'b0);
            end else if (m_wcnt + 1 == TMO) begin
                finish_txn(64'd0, 1'b1);
            end else begin
                m_wcnt++;
            end
            if (granted) begin
                m_busy = 1'b1; m_addr_phase = 1'b1; m_owner = win; m_last = win;
                m_mem_addr = m_paddr[win]; m_pend[win] = 1'b0;
            end
            if (r0) begin m_pend[0] = 1'b1; m_paddr[0] = a0; end
            if (r1) begin m_pend[1] = 1'b1; m_paddr[1] = a1; end
        end
        @(posedge CLK);
        #1;
        chk("mem_addr_valid", 64'(bus.MEM_ADDR_VALID), 64'(m_busy && m_addr_phase));
        chk("mem_addr", bus.MEM_ADDR, m_mem_addr);
        chk("busy", 64'(bus.BUSY), 64'(m_busy));
        chk("owner", 64'(bus.OWNER), 64'(m_owner));
        chk("resp0_valid", 64'(bus.RESP0_VALID), 64'(m_rv[0]));
        chk("resp0_data", bus.RESP0_DATA, m_rd[0]);
        chk("resp0_err", 64'(bus.RESP0_ERR), 64'(m_re[0]));
        chk("resp1_valid", 64'(bus.RESP1_VALID), 64'(m_rv[1]));
        chk("resp1_data", bus.RESP1_DATA, m_rd[1]);
        chk("resp1_err", 64'(bus.RESP1_ERR), 64'(m_re[1]));
        chk("resp_exclusive", 64'(bus.RESP0_VALID && bus.RESP1_VALID), 64'd0);
        @(negedge CLK);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 64'd0, 1'b0, 64'd0, rdy, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        RST = 1'b1;
        bus.REQ0_VALID = 1'b0; bus.REQ0_ADDR = 64'd0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_ADDR = 64'd0;
        bus.MEM_READY = 1'b0; bus.MEM_DATA_VALID = 1'b0; bus.MEM_DATA = 64'd0;
        @(negedge CLK);
        do_reset();
        do_reset();
        chk("reset_busy", 64'(bus.BUSY), 64'd0);
        chk("reset_owner", 64'(bus.OWNER), 64'd0);
        chk("reset_mem_addr", bus.MEM_ADDR, 64'd0);

        // single request, MEM_DATA at cycle 5
        step(1'b1, 64'h1000, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        idle(1'b1);
        chk("single_mav_c2", 64'(bus.MEM_ADDR_VALID), 64'd1);
        chk("single_addr_c2", bus.MEM_ADDR, 64'h1000);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'hCF, 1'b0);
        chk("single_rv_c6", 64'(bus.RESP0_VALID), 64'd1);
        chk("single_rd_c6", bus.RESP0_DATA, 64'hCF);
        chk("single_re_c6", 64'(bus.RESP0_ERR), 64'd0);
        idle(1'b1);
        chk("single_rv_c7", 64'(bus.RESP0_VALID), 64'd0);

        // simultaneous requests; a second pair arrives while port 0 is in flight
        do_reset();
        step(1'b1, 64'hA000, 1'b1, 64'hB000, 1'b1, 1'b0, 64'd0, 1'b0);
        idle(1'b1);
        chk("rr_first_owner", 64'(bus.OWNER), 64'd0);
        chk("rr_first_addr", bus.MEM_ADDR, 64'hA000);
        step(1'b1, 64'hA100, 1'b1, 64'hB100, 1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h11, 1'b0);
        idle(1'b1);
        chk("rr_second_owner", 64'(bus.OWNER), 64'd1);
        chk("rr_second_addr", bus.MEM_ADDR, 64'hB100);
        idle(1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h22, 1'b0);
        chk("rr_second_resp", 64'(bus.RESP1_VALID), 64'd1);
        idle(1'b1);
        chk("rr_third_owner", 64'(bus.OWNER), 64'd0);
        chk("rr_third_addr", bus.MEM_ADDR, 64'hA100);
        idle(1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h33, 1'b0);

        // backpressure: MEM_READY low for 4 cycles in ISSUE
        step(1'b1, 64'h5000, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("bp_mav_hold", 64'(bus.MEM_ADDR_VALID), 64'd1);
            chk("bp_addr_hold", bus.MEM_ADDR, 64'h5000);
        end
        idle(1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 64'h44, 1'b0);
        chk("bp_resp", bus.RESP0_DATA, 64'h44);

        // timeout on port 1, then late data ignored
        step(1'b0, 64'd0, 1'b1, 64'h7000, 1'b1, 1'b0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < TMO; i++) idle(1'b1);
        chk("tmo_rv", 64'(bus.RESP1_VALID), 64'd1);
        chk("tmo_err", 64'(bus.RESP1_ERR), 64'd1);
        chk("tmo_data", bus.RESP1_DATA, 64'd0);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h55, 1'b0);
        idle(1'b1);
        chk("tmo_late_ignored", 64'(bus.RESP1_VALID), 64'd0);

        // request arriving in the grant cycle of the same port
        step(1'b0, 64'd0, 1'b1, 64'h1000, 1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 64'h2000, 1'b1, 1'b0, 64'd0, 1'b0);
        chk("grant_race_addr1", bus.MEM_ADDR, 64'h1000);
        idle(1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h66, 1'b0);
        idle(1'b1);
        chk("grant_race_addr2", bus.MEM_ADDR, 64'h2000);
        chk("grant_race_mav2", 64'(bus.MEM_ADDR_VALID), 64'd1);
        idle(1'b1);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h77, 1'b0);

        // reset while in WAIT
        step(1'b0, 64'd0, 1'b1, 64'h3000, 1'b1, 1'b0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        chk("rst_wait_busy", 64'(bus.BUSY), 64'd0);
        step(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h88, 1'b0);
        chk("rst_wait_no_resp", 64'(bus.RESP1_VALID), 64'd0);
        idle(1'b1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 4) == 0, {$urandom, $urandom},
                 $urandom_range(0, 4) == 0, {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                 {$urandom, $urandom}, $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ptw_mem_arbiter.md
PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, page-table-walk address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, PTE data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before an error response (range 1..255).
REQ-004 SHALL have port CLK  in  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have port REQ0_VALID  in  1  a one-cycle walk-request pulse from the ITLB (port 0).
REQ-007 SHALL have port REQ0_ADDR  in  ADDR_WIDTH  the port-0 PTE address, sampled when REQ0_VALID=1.
REQ-008 SHALL have port RESP0_VALID  out  1  a one-cycle response pulse to port 0.
REQ-009 SHALL have port RESP0_DATA  out  DATA_WIDTH  the port-0 PTE data.
REQ-010 SHALL have port RESP0_ERR  out  1  the port-0 timeout flag, qualified by RESP0_VALID.
REQ-011 SHALL have ports REQ1_VALID, REQ1_ADDR, RESP1_VALID, RESP1_DATA and RESP1_ERR, identical to REQ-006..010 and serving the DTLB (port 1).
REQ-012 SHALL have port MEM_ADDR_VALID  out  1  the address request to the AXI master.
REQ-013 SHALL have port MEM_ADDR  out  ADDR_WIDTH  the address presented to the AXI master.
REQ-014 SHALL have port MEM_READY  in  1  the AXI master accepting the address.
REQ-015 SHALL have port MEM_DATA_VALID  in  1  the read-data strobe from the AXI master.
REQ-016 SHALL have port MEM_DATA  in  DATA_WIDTH  the read data from the AXI master.
REQ-017 SHALL have port BUSY  out  1  high whenever state!=IDLE.
REQ-018 SHALL have port OWNER  out  1  the port owning the current or last transaction.

Function
REQ-019 SHALL keep one pending flag plus one address register per port; REQn_VALID sets pendn and loads the address.
REQ-020 SHALL, on REQn_VALID while pendn=1, overwrite the address and keep pendn=1 (the last request wins).
REQ-021 SHALL implement the state machine IDLE -> ISSUE -> WAIT -> IDLE, with at most one memory transaction outstanding.
REQ-022 SHALL, in IDLE with any registered pendn=1, select a winner, copy its address into MEM_ADDR, clear its pendn, set OWNER and go to ISSUE.
REQ-023 SHALL, when both ports are pending, grant the port that is not last_grant (round-robin); last_grant updates on each grant.
REQ-024 SHALL, when REQn_VALID arrives in the same cycle its pendn is cleared by a grant, leave pendn=1 holding the new address.
REQ-025 SHALL, in ISSUE, hold MEM_ADDR_VALID=1 and MEM_ADDR stable until MEM_READY=1, then go to WAIT and clear the watchdog counter.
REQ-026 SHALL, in WAIT on MEM_DATA_VALID=1, register MEM_DATA into RESP<OWNER>_DATA, pulse RESP<OWNER>_VALID for exactly 1 cycle (the next cycle) with ERR=0, and go to IDLE.
REQ-027 SHALL, in WAIT, increment an 8-bit counter each cycle without MEM_DATA_VALID; on reaching TIMEOUT it SHALL pulse RESP<OWNER>_VALID with ERR=1 and DATA=0, then go to IDLE.
REQ-028 SHALL ignore MEM_DATA_VALID outside WAIT, including late data after a timeout.
REQ-029 SHALL never assert RESP0_VALID and RESP1_VALID in the same cycle.
REQ-030 SHALL hold RESPn_DATA and RESPn_ERR at their last values when RESPn_VALID=0.
REQ-031 SHALL have a minimum latency of REQ pulse at cycle 0 -> MEM_ADDR_VALID at cycle 2, and MEM_DATA_VALID at cycle k -> RESP at cycle k+1.
REQ-032 SHALL allow a pending request to be granted in the first IDLE cycle after a response.

Reset
REQ-033 SHALL, on RST=1, set state=IDLE, pend0=pend1=0, last_grant=1 (port 0 wins first), OWNER=0, counter=0, MEM_ADDR_VALID=0, MEM_ADDR=0, RESP*_VALID=0, RESP*_DATA=0, RESP*_ERR=0, BUSY=0.
REQ-034 SHALL, on reset mid-ISSUE or mid-WAIT, abandon the transaction with no response issued and discard pending requests.

Verification
REQ-035 SHALL cover a single request: REQ0 with addr 0x1000 at cycle 0, MEM_READY=1, MEM_DATA=0xCF at cycle 5 -> MEM_ADDR_VALID at cycle 2 with MEM_ADDR=0x1000, then RESP0_VALID=1 with DATA=0xCF and ERR=0 at cycle 6 only.
REQ-036 SHALL cover simultaneous requests: REQ0 (0xA000) and REQ1 (0xB000) in the same cycle after reset -> port 0 served first, port 1 second; repeating this -> port 1 first.
REQ-037 SHALL cover backpressure: MEM_READY low for 4 cycles -> MEM_ADDR_VALID and MEM_ADDR stable for all 4 cycles, WAIT entered only after MEM_READY=1.
REQ-038 SHALL cover timeout: TIMEOUT=8 with no MEM_DATA_VALID -> RESP1_VALID=1, ERR=1, DATA=0 after 8 WAIT cycles; later MEM_DATA_VALID produces no response.
REQ-039 SHALL cover a request during a grant: REQ1 (0x2000) in the cycle port 1 is granted (0x1000) -> second transaction to 0x2000 after the first response.
REQ-040 SHALL cover reset mid-operation: RST in WAIT -> BUSY=0 next cycle, no RESP pulse, and subsequent MEM_DATA_VALID ignored.
